// File: rtl/analog_pot_scan.sv
// POKEY-style pot scan for the 5200 core: turns signed analog axes into POTx
// values that settle one scan tick per count after a POTGO strobe.
module analog_pot_scan #(
    parameter int NUM_POTS = 4,
    parameter int CENTER   = 114,
    parameter int GAIN     = 107,
    parameter int POT_MIN  = 1,
    parameter int POT_MAX  = 228
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [8*NUM_POTS-1:0] axis,
    input  logic [NUM_POTS-1:0]   pot_enable,
    input  logic                  potgo,
    input  logic                  fast_mode,
    input  logic                  line_stb,
    input  logic                  fast_stb,
    output logic [8*NUM_POTS-1:0] pot_val,
    output logic [NUM_POTS-1:0]   allpot,
    output logic                  scan_active
);

    if (POT_MAX > 255 || POT_MIN < 1 || POT_MIN > POT_MAX) begin : g_param_chk
        $error("analog_pot_scan: POT_MIN/POT_MAX out of range");
    end

    localparam logic signed [15:0] GAIN_S   = 16'(GAIN);
    localparam logic signed [9:0]  CENTER_S = 10'(CENTER);
    localparam logic signed [9:0]  PMIN_S   = 10'(POT_MIN);
    localparam logic signed [9:0]  PMAX_S   = 10'(POT_MAX);
    localparam logic [7:0]         PMIN8    = 8'(POT_MIN);
    localparam logic [7:0]         PMAX8    = 8'(POT_MAX);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d, cnt_nx;
    logic [NUM_POTS-1:0][7:0]   pot_val_q, pot_val_d;
    logic [NUM_POTS-1:0][7:0]   tgt_q, tgt_d, tgt_c;
    logic [NUM_POTS-1:0]        allpot_q, allpot_d;
    logic                       fast_q, fast_d;
    logic                       tick;

    // Per-pot target: CENTER + (axis*GAIN >>> 7), clamped; absent pots read POT_MAX.
    for (genvar g = 0; g < NUM_POTS; g++) begin : g_tgt
        logic signed [15:0] ax16, prod;
        logic signed [9:0]  t;
        assign ax16 = 16'($signed(axis[8*g +: 8]));
        assign prod = ax16 * GAIN_S;
        assign t    = CENTER_S + 10'(prod >>> 7);
        assign tgt_c[g] = !pot_enable[g] ? PMAX8 :
                          (t < PMIN_S)   ? PMIN8 :
                          (t > PMAX_S)   ? PMAX8 : t[7:0];
    end

    assign tick   = fast_q ? fast_stb : line_stb;
    assign cnt_nx = cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pot_val_d = pot_val_q;
        tgt_d     = tgt_q;
        allpot_d  = allpot_q;
        fast_d    = fast_q;
        if (potgo) begin
            // Restart from any state; a coincident tick is dropped.
            state_d   = SCAN;
            cnt_d     = '0;
            pot_val_d = '0;
            tgt_d     = tgt_c;
            allpot_d  = '1;
            fast_d    = fast_mode;
        end else if (state_q == SCAN) begin
            if (tick && cnt_q != PMAX8) begin
                cnt_d = cnt_nx;
                for (int i = 0; i < NUM_POTS; i++) begin
                    if (allpot_q[i]) begin
                        if (cnt_nx >= tgt_q[i]) begin
                            pot_val_d[i] = tgt_q[i];
                            allpot_d[i]  = 1'b0;
                        end else begin
                            pot_val_d[i] = cnt_nx;
                        end
                    end
                end
            end
            if (allpot_q == '0) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pot_val_q <= '0;
            tgt_q     <= '0;
            allpot_q  <= '0;
            fast_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pot_val_q <= pot_val_d;
            tgt_q     <= tgt_d;
            allpot_q  <= allpot_d;
            fast_q    <= fast_d;
        end
    end

    assign pot_val     = pot_val_q;
    assign allpot      = allpot_q;
    assign scan_active = |allpot_q;

endmodule

// File: tb/tb_analog_pot_scan.sv
// Directed bench for analog_pot_scan; a second instance with GAIN=255 covers clamping.
module tb_analog_pot_scan;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] axis, axis_c;
    logic [3:0]  pot_enable;
    logic        potgo, fast_mode, line_stb, fast_stb;
    logic [31:0] pot_val, pot_val_c;
    logic [3:0]  allpot, allpot_c;
    logic        scan_active, scan_active_c;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    analog_pot_scan dut (
        .clk_sys(clk_sys), .reset(reset), .axis(axis), .pot_enable(pot_enable),
        .potgo(potgo), .fast_mode(fast_mode), .line_stb(line_stb), .fast_stb(fast_stb),
        .pot_val(pot_val), .allpot(allpot), .scan_active(scan_active)
    );

    analog_pot_scan #(.GAIN(255)) dut_c (
        .clk_sys(clk_sys), .reset(reset), .axis(axis_c), .pot_enable(4'b1111),
        .potgo(potgo), .fast_mode(fast_mode), .line_stb(line_stb), .fast_stb(fast_stb),
        .pot_val(pot_val_c), .allpot(allpot_c), .scan_active(scan_active_c)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_potgo();
        potgo = 1'b1;
        cyc(1);
        potgo = 1'b0;
    endtask

    task automatic slow_ticks(input int n);
        repeat (n) begin
            line_stb = 1'b1;
            cyc(1);
            line_stb = 1'b0;
            cyc(3);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        checks++; if (pot_val !== 32'h0) begin errors++; $display("FAIL reset_pot_val got %h want 0", pot_val); end
        checks++; if (allpot !== 4'b0) begin errors++; $display("FAIL reset_allpot got %b want 0000", allpot); end
        checks++; if (scan_active !== 1'b0) begin errors++; $display("FAIL reset_scan_active got %b want 0", scan_active); end
    endtask

    task automatic test_slow_scan();
        // fast_stb held high to show the unselected strobe is ignored
        fast_mode = 1'b0; fast_stb = 1'b1;
        pulse_potgo();
        checks++; if (allpot !== 4'b1111) begin errors++; $display("FAIL slow_start_allpot got %b want 1111", allpot); end
        checks++; if (pot_val !== 32'h0) begin errors++; $display("FAIL slow_start_pot_val got %h want 0", pot_val); end
        slow_ticks(6);
        checks++; if (pot_val[23:16] !== 8'd6 || allpot[2] !== 1'b1) begin errors++; $display("FAIL slow_t6_pot2 got %0d/%b want 6/1", pot_val[23:16], allpot[2]); end
        slow_ticks(1);
        checks++; if (pot_val[23:16] !== 8'd7 || allpot !== 4'b1011) begin errors++; $display("FAIL slow_t7_pot2 got %0d/%b want 7/1011", pot_val[23:16], allpot); end
        slow_ticks(43);
        checks++; if (pot_val[7:0] !== 8'd50 || allpot[0] !== 1'b1) begin errors++; $display("FAIL slow_t50_pot0 got %0d/%b want 50/1", pot_val[7:0], allpot[0]); end
        axis[7:0] = 8'h7f; pot_enable = 4'b0000;
        slow_ticks(63);
        checks++; if (pot_val[7:0] !== 8'd113 || allpot[0] !== 1'b1) begin errors++; $display("FAIL slow_t113_pot0 got %0d/%b want 113/1", pot_val[7:0], allpot[0]); end
        slow_ticks(1);
        checks++; if (pot_val[7:0] !== 8'd114 || allpot !== 4'b1010) begin errors++; $display("FAIL slow_t114_pot0 got %0d/%b want 114/1010", pot_val[7:0], allpot); end
        slow_ticks(105);
        checks++; if (pot_val[15:8] !== 8'd219 || allpot[1] !== 1'b1) begin errors++; $display("FAIL slow_t219_pot1 got %0d/%b want 219/1", pot_val[15:8], allpot[1]); end
        slow_ticks(1);
        checks++; if (pot_val[15:8] !== 8'd220 || allpot !== 4'b1000) begin errors++; $display("FAIL slow_t220_pot1 got %0d/%b want 220/1000", pot_val[15:8], allpot); end
        slow_ticks(7);
        checks++; if (pot_val[31:24] !== 8'd227 || scan_active !== 1'b1) begin errors++; $display("FAIL slow_t227_pot3 got %0d/%b want 227/1", pot_val[31:24], scan_active); end
        slow_ticks(1);
        checks++; if (pot_val !== {8'd228, 8'd7, 8'd220, 8'd114}) begin errors++; $display("FAIL slow_final got %h want e407dc72", pot_val); end
        checks++; if (allpot !== 4'b0 || scan_active !== 1'b0) begin errors++; $display("FAIL slow_done got %b/%b want 0000/0", allpot, scan_active); end
        slow_ticks(3);
        checks++; if (pot_val !== {8'd228, 8'd7, 8'd220, 8'd114}) begin errors++; $display("FAIL idle_hold got %h want e407dc72", pot_val); end
        fast_stb = 1'b0;
        axis[7:0] = 8'h00; pot_enable = 4'b0111;
    endtask

    task automatic test_fast_scan();
        fast_mode = 1'b1; fast_stb = 1'b1; line_stb = 1'b1;
        pulse_potgo();
        fast_mode = 1'b0;
        checks++; if (pot_val !== 32'h0 || allpot !== 4'b1111) begin errors++; $display("FAIL fast_start got %h/%b want 0/1111", pot_val, allpot); end
        cyc(7);
        checks++; if (pot_val[23:16] !== 8'd7 || allpot[2] !== 1'b0) begin errors++; $display("FAIL fast_t7_pot2 got %0d/%b want 7/0", pot_val[23:16], allpot[2]); end
        cyc(106);
        checks++; if (pot_val[7:0] !== 8'd113 || allpot[0] !== 1'b1) begin errors++; $display("FAIL fast_t113_pot0 got %0d/%b want 113/1", pot_val[7:0], allpot[0]); end
        cyc(1);
        checks++; if (pot_val[7:0] !== 8'd114 || allpot[0] !== 1'b0) begin errors++; $display("FAIL fast_t114_pot0 got %0d/%b want 114/0", pot_val[7:0], allpot[0]); end
        cyc(114);
        checks++; if (pot_val !== {8'd228, 8'd7, 8'd220, 8'd114} || scan_active !== 1'b0) begin errors++; $display("FAIL fast_final got %h/%b want e407dc72/0", pot_val, scan_active); end
        fast_stb = 1'b0; line_stb = 1'b0;
    endtask

    task automatic test_back_to_back();
        fast_mode = 1'b0;
        pulse_potgo();
        slow_ticks(100);
        checks++; if (pot_val[7:0] !== 8'd100 || allpot !== 4'b1011) begin errors++; $display("FAIL restart_t100 got %0d/%b want 100/1011", pot_val[7:0], allpot); end
        potgo = 1'b1; line_stb = 1'b1;
        cyc(1);
        potgo = 1'b0; line_stb = 1'b0;
        checks++; if (pot_val !== 32'h0 || allpot !== 4'b1111) begin errors++; $display("FAIL restart_collide got %h/%b want 0/1111", pot_val, allpot); end
        cyc(3);
        slow_ticks(113);
        checks++; if (pot_val[7:0] !== 8'd113 || allpot[0] !== 1'b1) begin errors++; $display("FAIL restart_t113 got %0d/%b want 113/1", pot_val[7:0], allpot[0]); end
        slow_ticks(1);
        checks++; if (pot_val[7:0] !== 8'd114 || allpot[0] !== 1'b0) begin errors++; $display("FAIL restart_t114 got %0d/%b want 114/0", pot_val[7:0], allpot[0]); end
    endtask

    task automatic test_reset_mid_scan();
        pulse_potgo();
        slow_ticks(60);
        checks++; if (pot_val[7:0] !== 8'd60) begin errors++; $display("FAIL mid_t60 got %0d want 60", pot_val[7:0]); end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++; if (pot_val !== 32'h0 || allpot !== 4'b0 || scan_active !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b/%b want 0/0000/0", pot_val, allpot, scan_active); end
        slow_ticks(5);
        checks++; if (pot_val !== 32'h0 || allpot !== 4'b0) begin errors++; $display("FAIL no_potgo_ticks got %h/%b want 0/0000", pot_val, allpot); end
        pulse_potgo();
        slow_ticks(1);
        checks++; if (pot_val[7:0] !== 8'd1) begin errors++; $display("FAIL post_reset_t1 got %0d want 1", pot_val[7:0]); end
    endtask

    task automatic test_clamp();
        fast_mode = 1'b1; fast_stb = 1'b1;
        pulse_potgo();
        cyc(1);
        checks++; if (pot_val_c[15:8] !== 8'd1 || allpot_c[1] !== 1'b0) begin errors++; $display("FAIL clamp_min got %0d/%b want 1/0", pot_val_c[15:8], allpot_c[1]); end
        cyc(227);
        checks++; if (pot_val_c !== {8'd114, 8'd114, 8'd1, 8'd228}) begin errors++; $display("FAIL clamp_final got %h want 727201e4", pot_val_c); end
        checks++; if (scan_active_c !== 1'b0) begin errors++; $display("FAIL clamp_done got %b want 0", scan_active_c); end
        fast_stb = 1'b0; fast_mode = 1'b0;
    endtask

    initial begin
        reset = 1'b1; potgo = 1'b0; fast_mode = 1'b0; line_stb = 1'b0; fast_stb = 1'b0;
        axis       = {8'h00, 8'h80, 8'h7f, 8'h00};
        axis_c     = {8'h00, 8'h00, 8'h80, 8'h7f};
        pot_enable = 4'b0111;
        test_reset();
        test_slow_scan();
        test_fast_scan();
        test_back_to_back();
        test_reset_mid_scan();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
